ov7670_dvp_source: RTL

Camera-side DVP transmitter that emulates an OV7670 in RGB444 mode. It reads 12-bit pixels from a frame buffer, or generates a test pattern, and drives pclk/vsync/href/data with OV7670-style frame timing. Its outputs connect directly to the `ov7670_capture` inputs. It serves as a loopback source for bring-up and simulation of the capture → frame_buffer → display path without a physical camera.

---
 rtl/ov7670_pkg.sv | 42 ++++
 rtl/dvp_line_timer.sv | 59 +++++
 rtl/ov7670_dvp_source.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ov7670_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_pkg
// Shared definitions for the OV7670 DVP source and capture blocks.
//   - dvp_state_t   : frame-timing FSM states of the DVP source
//   - c_*_msb/lsb   : RGB444 nibble positions inside a 12-bit pixel {R,G,B}
//   - c_byte_hi/lo  : slot parity carrying the high (R) / low (G,B) byte
//   - c_nb_slot/line: counter widths used by the line timer
//   - pack_rgb444() : optional R/B swap applied before serialising
// ---------------------------------------------------------------------------
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } dvp_state_t;

    localparam int c_r_msb = 11;
    localparam int c_r_lsb = 8;
    localparam int c_g_msb = 7;
    localparam int c_g_lsb = 4;
    localparam int c_b_msb = 3;
    localparam int c_b_lsb = 0;

    // Every pixel occupies two byte slots: the even slot carries {4'h0, R},
    // the odd slot carries {G, B}. The capture side relies on the same order.
    localparam logic c_byte_hi = 1'b0;
    localparam logic c_byte_lo = 1'b1;

    localparam int c_nb_slot = 12;
    localparam int c_nb_line = 10;

    function automatic logic [11:0] pack_rgb444(input logic [11:0] pxl,
                                                input logic        swap_r_b);
        if (swap_r_b)
            return {pxl[c_b_msb:c_b_lsb], pxl[c_g_msb:c_g_lsb], pxl[c_r_msb:c_r_lsb]};
        return pxl;
    endfunction

endpackage

// File: rtl/dvp_line_timer.sv
// ---------------------------------------------------------------------------
// dvp_line_timer
// Slot and line counters for the DVP source. The slot counter runs
// 0..c_line_slots-1 once per line; the line counter runs 0..last_line within
// the current FSM region and restarts at the start of every region.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : synchronous clear (held while the source is idle)
//   advance       : step one byte slot (falling-pclk launch edge)
//   last_line     : index of the final line of the current region
//   slot_cnt      : current byte slot within the line
//   line_cnt      : current line within the region
//   region_end    : strobe, last slot of the last line is being launched
// ---------------------------------------------------------------------------
module dvp_line_timer
    import ov7670_pkg::*;
#(
    parameter int c_line_slots = 176
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [c_nb_line-1:0] last_line,
    output logic [c_nb_slot-1:0] slot_cnt,
    output logic [c_nb_line-1:0] line_cnt,
    output logic                 region_end
);

    logic slot_last;
    logic line_end;

    assign slot_last  = (slot_cnt == c_nb_slot'(c_line_slots - 1));
    assign line_end   = advance && slot_last;
    assign region_end = line_end && (line_cnt == last_line);

    // Slots advance once per pclk period; the line counter wraps to zero at
    // the end of a region so each FSM region counts its own lines from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            line_cnt <= '0;
        end else if (clear) begin
            slot_cnt <= '0;
            line_cnt <= '0;
        end else if (advance) begin
            if (slot_last) begin
                slot_cnt <= '0;
                if (line_cnt == last_line)
                    line_cnt <= '0;
                else
                    line_cnt <= line_cnt + c_nb_line'(1);
            end else begin
                slot_cnt <= slot_cnt + c_nb_slot'(1);
            end
        end
    end

endmodule

// File: rtl/ov7670_dvp_source.sv
// ---------------------------------------------------------------------------
// ov7670_dvp_source
// Emulates an OV7670 camera in RGB444 mode: reads pixels from a frame buffer
// (or builds a test pattern) and drives pclk/vsync/href/data with OV7670
// style frame timing.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   enable      : start/continue frames (checked in IDLE and at frame end)
//   testmode    : 1 = internal pattern, 0 = frame-buffer pixels
//   swap_r_b    : swap R and B nibbles before serialising
//   rd_addr     : frame-buffer read address
//   rd_pxl      : frame-buffer read data, one clk after rd_addr
//   pclk        : pixel clock, clk/2
//   vsync, href : frame sync and line valid, active high
//   data        : DVP byte
//   frame_done  : one-clk pulse when the active region finishes
//   busy        : high while a frame is in progress
// ---------------------------------------------------------------------------
module ov7670_dvp_source
    import ov7670_pkg::*;
#(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_nb_buf       = 12,
    parameter int c_hblank       = 16,
    parameter int c_vsync_lines  = 3,
    parameter int c_vback_lines  = 2,
    parameter int c_vfront_lines = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     testmode,
    input  logic                     swap_r_b,
    output logic [c_nb_img_pxls-1:0] rd_addr,
    input  logic [c_nb_buf-1:0]      rd_pxl,
    output logic                     pclk,
    output logic                     vsync,
    output logic                     href,
    output logic [7:0]               data,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int c_line_slots = 2 * c_img_cols + c_hblank;
    localparam int c_img_pxls   = c_img_cols * c_img_rows;

    dvp_state_t           state_q;
    dvp_state_t           state_d;
    logic                 phase_q;
    logic                 launch;
    logic [c_nb_slot-1:0] slot_cnt;
    logic [c_nb_line-1:0] line_cnt;
    logic [c_nb_line-1:0] last_line;
    logic                 region_end;
    logic                 href_slot;
    logic                 byte_hi_slot;
    logic                 vsync_entry;
    logic [11:0]          pattern_pxl;
    logic [11:0]          src_pxl;
    logic [11:0]          packed_pxl;
    logic [7:0]           lo_byte_q;

    assign pclk = phase_q;
    assign busy = (state_q != ST_IDLE);

    // Outputs are only launched on the clk edge that takes pclk 1->0, so the
    // capture side always sees them settled at the rising pclk edge.
    assign launch       = phase_q && busy;
    assign href_slot    = (state_q == ST_ACTIVE) && (slot_cnt < c_nb_slot'(2 * c_img_cols));
    assign byte_hi_slot = (slot_cnt[0] == c_byte_hi);
    assign vsync_entry  = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);

    // Pattern pixel: column in R, row in G, constant 5 in B. The column is
    // the slot index halved, since each pixel takes two slots.
    assign pattern_pxl = {4'(slot_cnt >> 1), 4'(line_cnt), 4'h5};
    assign src_pxl     = testmode ? pattern_pxl : rd_pxl;
    assign packed_pxl  = pack_rgb444(src_pxl, swap_r_b);

    dvp_line_timer #(
        .c_line_slots(c_line_slots)
    ) u_line_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state_q == ST_IDLE),
        .advance   (launch),
        .last_line (last_line),
        .slot_cnt  (slot_cnt),
        .line_cnt  (line_cnt),
        .region_end(region_end)
    );

    // Number of lines in the region currently being sent, as a last index.
    always_comb begin
        last_line = '0;
        case (state_q)
            ST_VSYNC:  last_line = c_nb_line'(c_vsync_lines - 1);
            ST_VBACK:  last_line = c_nb_line'(c_vback_lines - 1);
            ST_ACTIVE: last_line = c_nb_line'(c_img_rows - 1);
            ST_VFRONT: last_line = c_nb_line'(c_vfront_lines - 1);
            default:   last_line = '0;
        endcase
    end

    // Frame sequencing. Once started, a frame always runs to the end of the
    // front porch; enable is only looked at in IDLE and at that boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable) state_d = ST_VSYNC;
            ST_VSYNC:  if (region_end) state_d = ST_VBACK;
            ST_VBACK:  if (region_end) state_d = ST_ACTIVE;
            ST_ACTIVE: if (region_end) state_d = ST_VFRONT;
            ST_VFRONT: if (region_end) state_d = enable ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Byte serialiser and frame-buffer address. The high byte is formed
    // straight from rd_pxl at its launch edge and the low byte is parked in
    // lo_byte_q for the following slot; the address steps on that same edge
    // so the next pixel has a full pixel period to come back from memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 1'b0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            lo_byte_q  <= 8'h00;
            rd_addr    <= '0;
            frame_done <= 1'b0;
        end else begin
            phase_q    <= busy ? ~phase_q : 1'b0;
            frame_done <= (state_q == ST_ACTIVE) && region_end;

            if (launch) begin
                vsync <= (state_q == ST_VSYNC);
                href  <= href_slot;
                if (!href_slot) begin
                    data <= 8'h00;
                end else if (byte_hi_slot) begin
                    data      <= {4'h0, packed_pxl[c_r_msb:c_r_lsb]};
                    lo_byte_q <= packed_pxl[c_g_msb:c_b_lsb];
                end else begin
                    data <= lo_byte_q;
                end
            end

            if (vsync_entry)
                rd_addr <= '0;
            else if (launch && href_slot && byte_hi_slot)
                rd_addr <= (rd_addr == c_nb_img_pxls'(c_img_pxls - 1)) ?
                           '0 : rd_addr + c_nb_img_pxls'(1);
        end
    end

endmodule
